// File: rtl/lpddr_chan_sched_pkg.sv
// Shared constants for the LPDDR channel scheduler: command codes, FSM state
// encoding and default timing values.
package lpddr_pkg;

    localparam int DEF_DEPTH     = 4;
    localparam int DEF_ROW_W     = 15;
    localparam int DEF_ID_W      = 9;
    localparam int DEF_BURST_LEN = 32;
    localparam int DEF_T_RS2CS   = 77;
    localparam int DEF_T_CS2R    = 40;
    localparam int DEF_T_CS2W    = 40;
    localparam int DEF_T_CS2REF  = 40;
    localparam int DEF_T_REFI    = 1950;
    localparam logic [14:0] DEF_ADDR_REF = 15'h700f;

    typedef enum logic [1:0] {
        CMD_ACT = 2'd0,
        CMD_RD  = 2'd1,
        CMD_WR  = 2'd2,
        CMD_REF = 2'd3
    } cmd_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WACT  = 3'd1,
        ST_WCOL  = 3'd2,
        ST_BURST = 3'd3,
        ST_WREF  = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lpddr_chan_sched_if.sv
// Request/command bus of the channel scheduler. Handshake: a request moves when
// req_valid and req_ready are both high at a clk edge; the command side has no back-pressure.
interface lpddr_chan_sched_if #(
    parameter int ROW_W     = 15,
    parameter int ID_W      = 9,
    parameter int BURST_LEN = 32
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [ROW_W-1:0]  req_row;
    logic              req_wen;
    logic [ID_W-1:0]   req_busID;
    logic              cmd_valid;
    logic [1:0]        cmd_code;
    logic [ROW_W-1:0]  cmd_row;
    logic              beat_en;
    logic [BEAT_W-1:0] beat_idx;
    logic              rd_done;
    logic [ID_W-1:0]   rd_busID;
    lpddr_pkg::state_e dbg_state;

    modport master (
        output req_valid, req_row, req_wen, req_busID,
        input  req_ready, cmd_valid, cmd_code, cmd_row, beat_en, beat_idx,
               rd_done, rd_busID, dbg_state
    );

    modport slave (
        input  req_valid, req_row, req_wen, req_busID,
        output req_ready, cmd_valid, cmd_code, cmd_row, beat_en, beat_idx,
               rd_done, rd_busID, dbg_state
    );

endinterface

// File: rtl/lpddr_req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap freely.
module lpddr_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/lpddr_chan_sched.sv
// Single-channel LPDDR command scheduler: queues requests, sequences ACT/RD/WR
// and data bursts, and slots periodic refreshes between requests.
module lpddr_chan_sched
    import lpddr_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int ID_W      = DEF_ID_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int T_RS2CS   = DEF_T_RS2CS,
    parameter int T_CS2R    = DEF_T_CS2R,
    parameter int T_CS2W    = DEF_T_CS2W,
    parameter int T_CS2REF  = DEF_T_CS2REF,
    parameter int T_REFI    = DEF_T_REFI,
    parameter logic [ROW_W-1:0] ADDR_REF = ROW_W'(DEF_ADDR_REF)
) (
    input logic               clk,
    input logic               rst,
    input logic               stall,
    lpddr_chan_sched_if.slave bus
);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int T_MAX   = max_int(max_int(T_RS2CS, T_CS2R), max_int(T_CS2W, T_CS2REF));
    localparam int TIMER_W = max_int(1, $clog2(T_MAX));
    localparam int REF_W   = max_int(1, $clog2(T_REFI));
    localparam int ENTRY_W = ROW_W + 1 + ID_W;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               ref_pend_q, ref_pend_d;
    logic               ref_expire, ref_issue;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [ROW_W-1:0]   head_row;
    logic               head_wen;
    logic [ID_W-1:0]    head_id;

    logic               cmd_valid, beat_en, rd_done;
    cmd_code_e          cmd_code;
    logic [ROW_W-1:0]   cmd_row;
    logic [ID_W-1:0]    rd_id;

    assign fifo_push = bus.req_valid && !fifo_full;
    assign {head_row, head_wen, head_id} = head;

    lpddr_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({bus.req_row, bus.req_wen, bus.req_busID}),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        beat_d    = beat_q;
        cmd_valid = 1'b0;
        cmd_code  = CMD_ACT;
        cmd_row   = '0;
        beat_en   = 1'b0;
        rd_done   = 1'b0;
        rd_id     = '0;
        fifo_pop  = 1'b0;
        ref_issue = 1'b0;
        if (!stall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ref_pend_q) begin
                        cmd_valid = 1'b1;
                        cmd_code  = CMD_REF;
                        cmd_row   = ADDR_REF;
                        ref_issue = 1'b1;
                        timer_d   = TIMER_W'(T_CS2REF - 1);
                        state_d   = ST_WREF;
                    end else if (!fifo_empty) begin
                        cmd_valid = 1'b1;
                        cmd_code  = CMD_ACT;
                        cmd_row   = head_row;
                        timer_d   = TIMER_W'(T_RS2CS - 1);
                        state_d   = ST_WACT;
                    end
                end
                ST_WACT: begin
                    if (timer_q == '0) begin
                        cmd_valid = 1'b1;
                        cmd_code  = head_wen ? CMD_WR : CMD_RD;
                        cmd_row   = head_row;
                        timer_d   = head_wen ? TIMER_W'(T_CS2W - 1) : TIMER_W'(T_CS2R - 1);
                        state_d   = ST_WCOL;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                // Timer reaches zero on the edge into BURST, so beat 0 lands
                // exactly T_CS2x cycles after the column command.
                ST_WCOL: begin
                    if (timer_q <= TIMER_W'(1)) begin
                        timer_d = '0;
                        beat_d  = '0;
                        state_d = ST_BURST;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_BURST: begin
                    beat_en = 1'b1;
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        fifo_pop = 1'b1;
                        rd_done  = !head_wen;
                        rd_id    = head_wen ? '0 : head_id;
                        beat_d   = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                ST_WREF: begin
                    if (timer_q <= TIMER_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Refresh interval keeps counting through stalls; a new expiry wins over
    // the clear from a REF issued in the same cycle.
    always_comb begin
        ref_expire = (ref_cnt_q == '0);
        ref_cnt_d  = ref_expire ? REF_W'(T_REFI - 1) : ref_cnt_q - REF_W'(1);
        ref_pend_d = ref_pend_q;
        if (ref_expire)     ref_pend_d = 1'b1;
        else if (ref_issue) ref_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            beat_q     <= '0;
            ref_cnt_q  <= REF_W'(T_REFI - 1);
            ref_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beat_q     <= beat_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_code  = cmd_code;
    assign bus.cmd_row   = cmd_row;
    assign bus.beat_en   = beat_en;
    assign bus.beat_idx  = beat_q;
    assign bus.rd_done   = rd_done;
    assign bus.rd_busID  = rd_id;
    assign bus.dbg_state = state_q;

endmodule
